// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - scalar core constants shared with the vector unit
package riscv_pkg;

  localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/riscv_v_pkg.sv
// rtl/riscv_v_pkg.sv - vector reduction types, element sizes and bytewise op helpers
package riscv_v_pkg;

  import riscv_pkg::*;

  localparam int RISCV_V_NUM_BYTES_DATA = 16;

  typedef logic [RISCV_V_NUM_BYTES_DATA-1:0][BYTE_WIDTH-1:0] riscv_v_src_byte_vector_t;

  typedef enum logic [1:0] {
    REDUCT_AND = 2'd0,
    REDUCT_OR  = 2'd1,
    REDUCT_XOR = 2'd2
  } reduct_op_t;

  typedef enum logic [1:0] {
    OSIZE_8  = 2'd0,
    OSIZE_16 = 2'd1,
    OSIZE_32 = 2'd2,
    OSIZE_64 = 2'd3
  } osize_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FOLD  = 2'd2,
    ST_DONE  = 2'd3
  } fold_state_e;

  function automatic logic [3:0] osize_bytes(input osize_t s);
    case (s)
      OSIZE_8:  return 4'd1;
      OSIZE_16: return 4'd2;
      OSIZE_32: return 4'd4;
      default:  return 4'd8;
    endcase
  endfunction

  // Value a masked-off byte takes so it cannot disturb the reduction.
  function automatic logic [BYTE_WIDTH-1:0] reduct_identity(input reduct_op_t op);
    return (op == REDUCT_AND) ? {BYTE_WIDTH{1'b1}} : {BYTE_WIDTH{1'b0}};
  endfunction

  function automatic logic [BYTE_WIDTH-1:0] reduct_apply(input reduct_op_t op,
                                                         input logic [BYTE_WIDTH-1:0] a,
                                                         input logic [BYTE_WIDTH-1:0] b);
    case (op)
      REDUCT_AND: return a & b;
      REDUCT_OR:  return a | b;
      default:    return a ^ b;
    endcase
  endfunction

endpackage

// File: rtl/riscv_v_reduct_fold_stage.sv
// rtl/riscv_v_reduct_fold_stage.sv - combines the two halves of the active byte window
module riscv_v_reduct_fold_stage
  import riscv_pkg::*;
  import riscv_v_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0][BYTE_WIDTH-1:0]   data_i,
  input  reduct_op_t                     op_i,
  input  logic [$clog2(N):0]             width_i,
  output logic [N/2-1:0][BYTE_WIDTH-1:0] result_o
);

  localparam int LW = $clog2(N);

  logic [LW:0] half;

  assign half = width_i >> 1;

  // Byte i pairs with byte i+half; bytes beyond the new window are cleared.
  always_comb begin
    for (int i = 0; i < N/2; i++) begin
      if ((LW+1)'(i) < half) begin
        result_o[i] = reduct_apply(op_i, data_i[i], data_i[LW'(i) + half[LW-1:0]]);
      end else begin
        result_o[i] = '0;
      end
    end
  end

endmodule

// File: rtl/riscv_v_reduct_fold_seq.sv
// rtl/riscv_v_reduct_fold_seq.sv - accumulates AND/OR/XOR result beats and folds them to one scalar
module riscv_v_reduct_fold_seq
  import riscv_pkg::*;
  import riscv_v_pkg::*;
#(
  parameter int NUM_BYTES = RISCV_V_NUM_BYTES_DATA
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] in_data,
  input  logic [NUM_BYTES-1:0]                in_byte_valid,
  input  reduct_op_t                          op,
  input  osize_t                              osize,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [63:0]                         out_data,
  output logic                                busy
);

  localparam int WW = $clog2(NUM_BYTES) + 1;
  localparam int CW = $clog2(2*NUM_BYTES) + 1;

  fold_state_e                          state_q, state_d;
  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] acc_q, acc_d;
  reduct_op_t                           op_q, op_d;
  osize_t                               osize_q, osize_d;
  logic [WW-1:0]                        width_q, width_d;

  logic                                   accept;
  logic                                   first_beat;
  logic                                   fold_last;
  reduct_op_t                             op_eff;
  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0]   masked;
  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0]   combined;
  logic [NUM_BYTES/2-1:0][BYTE_WIDTH-1:0] folded;
  logic [63:0]                            acc_lo;
  logic [63:0]                            result;

  assign accept     = in_valid & in_ready;
  assign first_beat = (state_q == ST_IDLE);
  assign op_eff     = first_beat ? op : op_q;
  assign fold_last  = (width_q >> 1) == WW'(osize_bytes(osize_q));

  always_comb begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      masked[i] = in_byte_valid[i] ? in_data[i] : reduct_identity(op_eff);
    end
  end

  // Beat combine reuses the fold stage over {beat, acc} with a full-width window.
  riscv_v_reduct_fold_stage #(.N(2*NUM_BYTES)) u_combine (
    .data_i   ({masked, acc_q}),
    .op_i     (op_q),
    .width_i  (CW'(2*NUM_BYTES)),
    .result_o (combined)
  );

  riscv_v_reduct_fold_stage #(.N(NUM_BYTES)) u_fold (
    .data_i   (acc_q),
    .op_i     (op_q),
    .width_i  (width_q),
    .result_o (folded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = in_last ? ST_FOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (accept && in_last) state_d = ST_FOLD;
      end
      ST_FOLD: begin
        if (fold_last) state_d = ST_DONE;
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  assign acc_lo = acc_q[7:0];

  always_comb begin
    case (osize_q)
      OSIZE_8:  result = {56'd0, acc_lo[7:0]};
      OSIZE_16: result = {48'd0, acc_lo[15:0]};
      OSIZE_32: result = {32'd0, acc_lo[31:0]};
      default:  result = acc_lo;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
    out_data  = out_valid ? result : 64'd0;
  end

  always_comb begin
    acc_d   = acc_q;
    op_d    = op_q;
    osize_d = osize_q;
    width_d = width_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          width_d = WW'(NUM_BYTES);
          if (first_beat) begin
            acc_d   = masked;
            op_d    = op;
            osize_d = osize;
          end else begin
            acc_d = combined;
          end
        end
      end
      ST_FOLD: begin
        acc_d                  = '0;
        acc_d[NUM_BYTES/2-1:0] = folded;
        width_d                = width_q >> 1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      op_q    <= REDUCT_AND;
      osize_q <= OSIZE_8;
      width_q <= WW'(NUM_BYTES);
    end else begin
      acc_q   <= acc_d;
      op_q    <= op_d;
      osize_q <= osize_d;
      width_q <= width_d;
    end
  end

endmodule

// File: tb/tb_riscv_v_reduct_fold_seq.sv
// tb/tb_riscv_v_reduct_fold_seq.sv - directed checks of the reduction fold sequencer
module tb_riscv_v_reduct_fold_seq;

  import riscv_v_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [15:0][7:0] in_data;
  logic [15:0]      in_byte_valid;
  reduct_op_t       op;
  osize_t           osize;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_v_reduct_fold_seq dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .in_data       (in_data),
    .in_byte_valid (in_byte_valid),
    .op            (op),
    .osize         (osize),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] bv, input logic last,
                           input reduct_op_t o, input osize_t s, input string tag);
    in_valid      = 1'b1;
    in_data       = d;
    in_byte_valid = bv;
    in_last       = last;
    op            = o;
    osize         = s;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_data       = '0;
    in_byte_valid = '0;
  endtask

  // Called one cycle after the last-beat handshake; counts cycles to out_valid.
  task automatic wait_valid(input string tag, input int exp_lat, input logic [63:0] exp_data);
    int n = 1;
    check({tag, "_fold_out_data"}, out_data, 64'd0);
    check({tag, "_fold_busy"}, 64'(busy), 64'd1);
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_data"}, out_data, exp_data);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ret_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ret_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_data       = '0;
    in_byte_valid = '0;
    op            = REDUCT_XOR;
    osize         = OSIZE_8;
    out_ready     = 1'b0;
    tick();
    tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // XOR of bytes 0x01..0x10 at 8-bit width: 1^..^15 = 0, ^16 = 0x10.
    send_beat(128'h100F0E0D0C0B0A090807060504030201, 16'hFFFF, 1'b1, REDUCT_XOR, OSIZE_8, "xor8");
    wait_valid("xor8", 5, 64'h10);
    release_result("xor8");

    // Op/osize on the second beat must be ignored.
    send_beat(128'h01, 16'hFFFF, 1'b0, REDUCT_OR, OSIZE_16, "or16_b0");
    check("or16_accum_busy", 64'(busy), 64'd1);
    send_beat(128'h80000000, 16'hFFFF, 1'b1, REDUCT_AND, OSIZE_8, "or16_b1");
    wait_valid("or16", 4, 64'h8001);
    release_result("or16");

    // Invalid bytes become 0xFF for AND, leaving byte0 intact.
    send_beat(128'hF0, 16'h0001, 1'b1, REDUCT_AND, OSIZE_8, "and8");
    wait_valid("and8", 5, 64'hF0);
    release_result("and8");

    send_beat(128'h0123456789ABCDEF_FFFFFFFF00000000, 16'hFFFF, 1'b1, REDUCT_XOR, OSIZE_64, "xor64");
    wait_valid("xor64", 2, 64'hFEDCBA9889ABCDEF);
    for (int c = 0; c < 3; c++) begin
      in_valid      = 1'b1;
      in_last       = 1'b1;
      in_byte_valid = 16'hFFFF;
      in_data       = {16{8'h5A}};
      tick();
      check("xor64_hold_valid", 64'(out_valid), 64'd1);
      check("xor64_hold_data", out_data, 64'hFEDCBA9889ABCDEF);
      check("xor64_hold_in_ready", 64'(in_ready), 64'd0);
      check("xor64_hold_busy", 64'(busy), 64'd1);
    end
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_byte_valid = '0;
    in_data       = '0;
    release_result("xor64");
    check("xor64_idle_busy", 64'(busy), 64'd0);

    send_beat(128'h100F0E0D0C0B0A090807060504030201, 16'hFFFF, 1'b1, REDUCT_XOR, OSIZE_8, "rst_fold");
    check("rst_fold_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_fold_out_valid", 64'(out_valid), 64'd0);
    check("rst_fold_in_ready", 64'(in_ready), 64'd1);
    check("rst_fold_busy_low", 64'(busy), 64'd0);
    check("rst_fold_out_data", out_data, 64'd0);
    for (int c = 0; c < 5; c++) tick();
    check("rst_fold_stays_idle", 64'(out_valid), 64'd0);

    // Bytes 0..15 with byte4 ^= 0xAA (0xFF in byte0 is masked), folded to 32 bits -> 0xAA.
    send_beat(128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 1'b0, REDUCT_XOR, OSIZE_32, "xor32_b0");
    send_beat(128'h000000AA000000FF, 16'h0010, 1'b1, REDUCT_XOR, OSIZE_32, "xor32_b1");
    wait_valid("xor32", 3, 64'hAA);
    release_result("xor32");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
